// File: rtl/data_memory_block.sv
// -----------------------------------------------------------------------------
// data_memory_block
//
// Memory stage of the 16-bit MIPS pipeline. Sits between execute and
// write_back_block. Loads and stores go to an internal word-addressed data
// memory; ALU results bypass the memory. The stage result is registered onto
// ans_dm, so the latency from stage inputs to ans_dm/valid_out is one cycle.
//
// Stage flow control: valid_in marks an instruction present in the stage and
// stall holds the stage. On a clock edge with stall=1 nothing changes (no
// write, ans_dm/valid_out hold). With stall=0 the stage advances: valid_out
// takes valid_in, and only when valid_in=1 is ans_dm updated or memory
// written. There is no ready signal; the stall input is the only backpressure.
//
// Optional feature (macro DM_ADDR_CHECK_EN): adds addr_err. Any valid,
// non-stalled access whose ans_ex has nonzero bits above ADDR_W is flagged;
// such a store is dropped and such a load returns zero. Without the macro,
// upper address bits are ignored and addresses wrap modulo 2**ADDR_W.
//
// Ports:
//   clk            in   pipeline clock, rising edge
//   reset          in   asynchronous active-low reset (also clears memory)
//   ans_ex         in   execute result: ALU value or effective address
//   dm_data        in   store data
//   mem_en_ex      in   memory access enable
//   mem_rw_ex      in   1 = store, 0 = load (qualified by mem_en_ex)
//   mem_mux_sel_dm in   1 = ans_dm takes memory read data, 0 = ans_ex
//   valid_in       in   instruction present in stage
//   stall          in   hold the stage this cycle
//   ans_dm         out  registered stage result to write-back
//   valid_out      out  registered valid to write-back
//   addr_err       out  (DM_ADDR_CHECK_EN only) out-of-range access flag
// -----------------------------------------------------------------------------
module data_memory_block #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] dm_data,
  input  logic              mem_en_ex,
  input  logic              mem_rw_ex,
  input  logic              mem_mux_sel_dm,
  input  logic              valid_in,
  input  logic              stall,
  output logic [DATA_W-1:0] ans_dm,
  output logic              valid_out
`ifdef DM_ADDR_CHECK_EN
  ,
  output logic              addr_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] addr;
  logic              advance;
  logic              is_store;
  logic              is_load;
  logic              range_err;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] next_ans;

  assign addr     = ans_ex[ADDR_W-1:0];
  assign advance  = valid_in && !stall;
  assign is_store = mem_en_ex && mem_rw_ex;
  assign is_load  = mem_en_ex && !mem_rw_ex;

`ifdef DM_ADDR_CHECK_EN
  assign range_err = advance && mem_en_ex && (|ans_ex[DATA_W-1:ADDR_W]);
`else
  // Upper address bits are deliberately ignored (wrap-around addressing).
  logic unused_upper_addr;
  assign unused_upper_addr = |ans_ex[DATA_W-1:ADDR_W];
  assign range_err = 1'b0;
`endif

  assign wr_en   = advance && is_store && !range_err;
  // Combinational read; the value is captured by the ans_dm register.
  assign rd_data = mem[addr];

  always_comb begin
    next_ans = '0;
    if (!mem_mux_sel_dm) begin
      next_ans = ans_ex;
    end else if (is_load && !range_err) begin
      next_ans = rd_data;
    end
  end

  // Data memory: cleared on reset; a store coinciding with reset is lost
  // because the reset branch has priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[addr] <= dm_data;
    end
  end

  // Stage output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ans_dm    <= '0;
      valid_out <= 1'b0;
    end else if (!stall) begin
      valid_out <= valid_in;
      if (valid_in) begin
        ans_dm <= next_ans;
      end
    end
  end

`ifdef DM_ADDR_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_err <= 1'b0;
    end else if (!stall) begin
      addr_err <= range_err;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_block.sv
// -----------------------------------------------------------------------------
// tb_data_memory_block
//
// Directed bench for data_memory_block: a table of per-cycle vectors with
// hand-computed results, plus hand-written sequences around reset.
// -----------------------------------------------------------------------------
module tb_data_memory_block;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] ans_ex;
  logic [DATA_W-1:0] dm_data;
  logic              mem_en_ex;
  logic              mem_rw_ex;
  logic              mem_mux_sel_dm;
  logic              valid_in;
  logic              stall;
  logic [DATA_W-1:0] ans_dm;
  logic              valid_out;
`ifdef DM_ADDR_CHECK_EN
  logic              addr_err;
`endif

  data_memory_block #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .ans_ex         (ans_ex),
    .dm_data        (dm_data),
    .mem_en_ex      (mem_en_ex),
    .mem_rw_ex      (mem_rw_ex),
    .mem_mux_sel_dm (mem_mux_sel_dm),
    .valid_in       (valid_in),
    .stall          (stall),
    .ans_dm         (ans_dm),
    .valid_out      (valid_out)
`ifdef DM_ADDR_CHECK_EN
    ,
    .addr_err       (addr_err)
`endif
  );

  // ---------------- scoreboard ----------------
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              stall;
    logic              valid_in;
    logic              en;
    logic              rw;
    logic              sel;
    logic [DATA_W-1:0] ans_ex;
    logic [DATA_W-1:0] dm_data;
    logic [DATA_W-1:0] exp_ans;
    logic              exp_valid;
    logic              exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic vi, input logic en,
                              input logic rw, input logic sel,
                              input logic [DATA_W-1:0] a,
                              input logic [DATA_W-1:0] d,
                              input logic [DATA_W-1:0] ea, input logic ev,
                              input logic ee);
    vec_t v;
    v.stall = st; v.valid_in = vi; v.en = en; v.rw = rw; v.sel = sel;
    v.ans_ex = a; v.dm_data = d; v.exp_ans = ea; v.exp_valid = ev;
    v.exp_err = ee;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic st, input logic vi, input logic en,
                       input logic rw, input logic sel,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d);
    stall = st; valid_in = vi; mem_en_ex = en; mem_rw_ex = rw;
    mem_mux_sel_dm = sel; ans_ex = a; dm_data = d;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    @(negedge clk);
    drive(v.stall, v.valid_in, v.en, v.rw, v.sel, v.ans_ex, v.dm_data);
    @(posedge clk);
    #1;
    check($sformatf("vec%0d_ans_dm", idx), ans_dm, v.exp_ans);
    check($sformatf("vec%0d_valid_out", idx), {15'b0, valid_out}, {15'b0, v.exp_valid});
`ifdef DM_ADDR_CHECK_EN
    check($sformatf("vec%0d_addr_err", idx), {15'b0, addr_err}, {15'b0, v.exp_err});
`endif
  endtask

  logic [DATA_W-1:0] wrap_load_exp;
  logic              wrap_store_err;

  initial begin
`ifdef DM_ADDR_CHECK_EN
    wrap_load_exp  = 16'h0000;
    wrap_store_err = 1'b1;
`else
    wrap_load_exp  = 16'h5A5A;
    wrap_store_err = 1'b0;
`endif

    //            st vi en rw sel ans_ex    dm_data   exp_ans   ev ee
    vecs.push_back(mk(0, 1, 1, 0, 1, 16'h0012, 16'h0000, 16'h0000, 1, 0)); // memory cleared by reset
    vecs.push_back(mk(0, 1, 1, 1, 0, 16'h0005, 16'hABCD, 16'h0005, 1, 0)); // store, ALU value out
    vecs.push_back(mk(0, 1, 1, 0, 1, 16'h0005, 16'h0000, 16'hABCD, 1, 0)); // load right after store
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'hFFFF, 16'h0000, 16'hFFFF, 1, 0)); // ALU bypass
    vecs.push_back(mk(0, 1, 1, 0, 1, 16'h00FF, 16'h0000, 16'h0000, 1, 0)); // bypass did not write
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'hDCBA, 16'h0000, 16'hDCBA, 1, 0)); // set up held value
    vecs.push_back(mk(1, 1, 1, 1, 0, 16'h0010, 16'h1111, 16'hDCBA, 1, 0)); // stall 1
    vecs.push_back(mk(1, 1, 1, 1, 0, 16'h0010, 16'h1111, 16'hDCBA, 1, 0)); // stall 2
    vecs.push_back(mk(1, 1, 1, 1, 0, 16'h0010, 16'h1111, 16'hDCBA, 1, 0)); // stall 3
    vecs.push_back(mk(0, 0, 1, 1, 0, 16'h0010, 16'h1111, 16'hDCBA, 0, 0)); // bubble
    vecs.push_back(mk(0, 1, 1, 0, 1, 16'h0010, 16'h0000, 16'h0000, 1, 0)); // no write happened
    vecs.push_back(mk(0, 1, 1, 1, 0, 16'h0103, 16'h5A5A, 16'h0103, 1, wrap_store_err)); // wrap store
    vecs.push_back(mk(0, 1, 1, 0, 1, 16'h0003, 16'h0000, wrap_load_exp, 1, 0));        // wrap load
    vecs.push_back(mk(0, 1, 1, 1, 1, 16'h0000, 16'h1357, 16'h0000, 1, 0)); // store, sel=1 -> zero
    vecs.push_back(mk(0, 1, 1, 1, 0, 16'h00FF, 16'h2468, 16'h00FF, 1, 0)); // store top address
    vecs.push_back(mk(0, 1, 1, 0, 1, 16'h00FF, 16'h0000, 16'h2468, 1, 0)); // back-to-back loads
    vecs.push_back(mk(0, 1, 1, 0, 1, 16'h0000, 16'h0000, 16'h1357, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 16'h0005, 16'h0000, 16'h0000, 1, 0)); // sel=1, no access
    vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0005, 16'h0000, 16'h0005, 1, 0)); // load with bypass
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h7777, 16'h0000, 16'h0005, 1, 0)); // stall holds valid
    vecs.push_back(mk(0, 1, 1, 0, 1, 16'h0005, 16'h0000, 16'hABCD, 1, 0)); // earlier data intact

    // ---- reset at time zero ----
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    #2;
    check("por_ans_dm", ans_dm, 16'h0000);
    check("por_valid_out", {15'b0, valid_out}, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    // ---- put data in memory and a value in ans_dm before a mid-run reset ----
    @(negedge clk);
    drive(0, 1, 1, 1, 0, 16'h0012, 16'h7777);
    @(posedge clk);
    #1;
    check("pre_reset_ans_dm", ans_dm, 16'h0012);
    check("pre_reset_valid_out", {15'b0, valid_out}, 16'h0001);

    // ---- asynchronous reset mid-cycle, with a store presented ----
    @(negedge clk);
    drive(0, 1, 1, 1, 0, 16'h1234, 16'hBEEF);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_ans_dm", ans_dm, 16'h0000);
    check("async_reset_valid_out", {15'b0, valid_out}, 16'h0000);
    @(posedge clk);
    #1;
    check("reset_hold_ans_dm", ans_dm, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    // ---- table-driven vectors ----
    foreach (vecs[i]) begin
      apply_vec(i, vecs[i]);
    end

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/data_memory_block.md
Name: data_memory_block

Overview:
- Memory stage of the 16-bit MIPS pipeline; sits between the execute stage and write_back_block.
- Performs loads and stores against an internal word-addressed data memory.
- Registers the stage result onto ans_dm, which write_back_block consumes.
- ALU results bypass the memory straight to ans_dm.
- Supports pipeline stall and bubble (valid) handling.

Parameters:
- DATA_W, 16, data and result width.
- ADDR_W, 8, address bits used from ans_ex; memory depth = 2**ADDR_W words.

Ports:
- clk  input  1  pipeline clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- ans_ex  input  DATA_W  execute-stage result; ALU result or effective address.
- dm_data  input  DATA_W  store data.
- mem_en_ex  input  1  memory access enable.
- mem_rw_ex  input  1  1 = store, 0 = load (qualified by mem_en_ex).
- mem_mux_sel_dm  input  1  1 = ans_dm takes memory read data, 0 = ans_dm takes ans_ex.
- valid_in  input  1  instruction present in stage.
- stall  input  1  hold stage this cycle.
- ans_dm  output  DATA_W  registered stage result to write-back.
- valid_out  output  1  registered valid to write-back.

Behaviour:
- Reset, asynchronous, reset=0:
  - ans_dm = 16'h0000, valid_out = 0.
  - All memory words cleared to 0.
  - Takes effect immediately, independent of clk.
  - A store presented in the same cycle as reset is discarded.
- Address = ans_ex[ADDR_W-1:0]. Upper bits are ignored, so addresses wrap modulo 2**ADDR_W.
- Stall = 1 (takes priority over all else):
  - No memory write.
  - ans_dm and valid_out hold their values.
- Bubble (stall = 0, valid_in = 0):
  - No memory write.
  - valid_out <= 0; ans_dm holds.
- Valid instruction (stall = 0, valid_in = 1), valid_out <= 1, and:
  - Store (mem_en_ex = 1, mem_rw_ex = 1): mem[addr] <= dm_data on the clock edge. ans_dm <= ans_ex when mem_mux_sel_dm = 0, else 16'h0000.
  - Load (mem_en_ex = 1, mem_rw_ex = 0) with mem_mux_sel_dm = 1: ans_dm <= mem[addr].
  - mem_mux_sel_dm = 0, any access type: ans_dm <= ans_ex (ALU pass-through).
  - mem_mux_sel_dm = 1 without a load: ans_dm <= 16'h0000.
- Latency: exactly one cycle from stage inputs to ans_dm/valid_out.
- Store followed by load to the same address on the next cycle returns the new data. The write completes at edge N; the read is sampled at edge N+1.
- Memory read is synchronous-output: the memory array is read combinationally and the result is captured in the ans_dm register.
- Only one memory operation per cycle, so there is no simultaneous read/write conflict.
- Store data wider than DATA_W cannot occur; no sign/zero extension is performed in this stage.

Optional Feature:
- Macro: DM_ADDR_CHECK_EN.
- Defined:
  - Adds output addr_err (1 bit; reset value 0).
  - When a valid, non-stalled access (mem_en_ex = 1) has any nonzero bit in ans_ex[DATA_W-1:ADDR_W]:
    - A store is suppressed.
    - A load returns 16'h0000.
    - addr_err <= 1 for that cycle.
  - Otherwise addr_err <= 0 on each non-stalled edge; it holds during a stall.
- Not defined: no addr_err port; out-of-range addresses wrap silently as described under Behaviour.

Test Plan:
- Reset: assert reset = 0 mid-cycle with ans_ex = 16'h1234, valid_in = 1 -> ans_dm = 16'h0000 and valid_out = 0 immediately. After release, a load from 0x12 -> 16'h0000.
- Store then load: store dm_data = 16'hABCD at ans_ex = 16'h0005, then next cycle load with mem_mux_sel_dm = 1 at 16'h0005 -> ans_dm = 16'hABCD, valid_out = 1 one cycle later.
- ALU bypass: ans_ex = 16'hFFFF, mem_en_ex = 0, mem_mux_sel_dm = 0 -> ans_dm = 16'hFFFF after one edge. Memory at 0xFF is unchanged (load -> 16'h0000).
- Stall/bubble:
  - ans_dm = 16'hDCBA; stall = 1 for 3 cycles while presenting a store of 16'h1111 to 0x10 -> ans_dm stays 16'hDCBA, and a later load of 0x10 returns 16'h0000.
  - valid_in = 0 -> valid_out = 0 and ans_dm holds.
- Wrap-around: store 16'h5A5A at ans_ex = 16'h0103 -> a load at 16'h0003 returns 16'h5A5A. With DM_ADDR_CHECK_EN defined: the store is suppressed, addr_err = 1 for one cycle, and the load returns 16'h0000.
- Back-to-back: stores to 0x00 and 0xFF, then loads of 0xFF and 0x00 in consecutive cycles -> the ans_dm sequence matches the stored data, one result per cycle with no gaps.
